// File: rtl/zigbee_fifo_pkg.sv
// Shared types and APB constants for the Zigbee FIFO datapath (RX and TX sides).
package zigbee_fifo_pkg;
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_STORE = 2'd2
   } rx_state_t;

   localparam logic PREADY_ZW = 1'b1;
   localparam logic ERR_NONE  = 1'b0;
   localparam logic ERR_SLV   = 1'b1;
endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with wrap-bit pointers and a combinational read port.
// The caller decides when a push is legal; this core only stores and counts.
module sync_fifo_core #(
   parameter int  WIDTH     = 8,
   parameter int  DEPTH     = 64,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_data,
   output logic                 full,
   output logic                 empty,
   output logic [PTR_WIDTH:0]   level
);
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;

   assign wr_ptr_d = push ? wr_ptr_q + (PTR_WIDTH+1)'(1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + (PTR_WIDTH+1)'(1) : rd_ptr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is left uninitialised on reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                     (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
   assign level    = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/fifo_rx_apb.sv
// Zigbee receive buffer: LSB-first bit deserialiser feeding a FIFO that the CPU
// drains through a read-only, zero-wait-state APB slave.
module fifo_rx_apb
   import zigbee_fifo_pkg::*;
#(
   parameter int  WIDTH     = 8,
   parameter int  DEPTH     = 64,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               data_in,
   input  logic               bit_valid,
   input  logic               en_rx,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   output logic [WIDTH-1:0]   prdata,
   output logic               pready,
   output logic               pslverr,
   output logic               mem_state,
   output logic [PTR_WIDTH:0] level,
   output logic               overflow
);
   localparam int CNT_W = $clog2(WIDTH);

   rx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] rx_word_q, rx_word_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic             overflow_q, overflow_d;
   logic             last_bit, store;
   logic             rd_acc, wr_acc, pop, push;
   logic             full, empty;
   logic [WIDTH-1:0] pop_data;

   assign last_bit = (bitcnt_q == CNT_W'(WIDTH-1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RX_IDLE;
         shreg_q    <= '0;
         rx_word_q  <= '0;
         bitcnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         rx_word_q  <= rx_word_d;
         bitcnt_q   <= bitcnt_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:  if (en_rx) state_d = RX_SHIFT;
         RX_SHIFT: begin
            if (!en_rx)                    state_d = RX_IDLE;
            else if (bit_valid && last_bit) state_d = RX_STORE;
         end
         RX_STORE: state_d = en_rx ? RX_SHIFT : RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   // The store cycle still listens to the line so back-to-back words lose no bit.
   always_comb begin
      shreg_d   = shreg_q;
      rx_word_d = rx_word_q;
      bitcnt_d  = bitcnt_q;
      store     = 1'b0;
      case (state_q)
         RX_SHIFT: begin
            if (!en_rx) begin
               bitcnt_d = '0;
            end else if (bit_valid) begin
               shreg_d[bitcnt_q] = data_in;
               if (last_bit) begin
                  rx_word_d = shreg_d;
                  bitcnt_d  = '0;
               end else begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
               end
            end
         end
         RX_STORE: begin
            store = 1'b1;
            if (en_rx && bit_valid) begin
               shreg_d[0] = data_in;
               bitcnt_d   = CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign rd_acc = psel & penable & ~pwrite;
   assign wr_acc = psel & penable & pwrite;
   assign pop    = rd_acc & ~empty;
   // A pop in the store cycle frees the slot the incoming word needs.
   assign push   = store & (~full | pop);

   always_comb begin
      overflow_d = overflow_q;
      if (rd_acc && !en_rx)         overflow_d = 1'b0;
      if (store && full && !pop)    overflow_d = 1'b1;
   end

   sync_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_core (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (rx_word_q),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign prdata    = pop ? pop_data : '0;
   assign pslverr   = (wr_acc || (rd_acc && empty)) ? ERR_SLV : ERR_NONE;
   assign pready    = PREADY_ZW;
   assign mem_state = ~empty;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_fifo_rx_apb.sv
// Randomised bench for fifo_rx_apb: a queue-based model of the received word
// stream is compared against every APB read and the status outputs.
module tb_fifo_rx_apb;
   localparam int DEPTH = 64;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       data_in = 1'b0, bit_valid = 1'b0, en_rx = 1'b0;
   logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0] prdata;
   logic       pready, pslverr, mem_state, overflow;
   logic [6:0] level;

   int         err_cnt = 0;
   int         chk_cnt = 0;
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;
   int         pending = 0;
   bit         sent_done = 1'b0;

   fifo_rx_apb #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_in   (data_in),
      .bit_valid (bit_valid),
      .en_rx     (en_rx),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .mem_state (mem_state),
      .level     (level),
      .overflow  (overflow)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [7:0] w);
      if (q.size() < DEPTH) q.push_back(w);
      else                  m_ovf = 1'b1;
      pending--;
   endtask

   task automatic send_bit(input logic b);
      data_in   = b;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
   endtask

   // gap < 0 selects a random inter-bit gap of 0..3 cycles.
   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) repeat (gap < 0 ? $urandom_range(0, 3) : gap) tick();
         send_bit(w[i]);
      end
      pending++;
      fork
         begin
            logic [7:0] wv = w;
            @(posedge clk);
            #1;
            model_push(wv);
         end
      join_none
   endtask

   task automatic apb_read_chk(input string tag);
      logic [7:0] exp_d;
      logic       exp_e;
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0;
      tick();
      penable = 1'b1;
      @(negedge clk);
      check_eq({tag, "_lvl"}, 32'(level), 32'(q.size()));
      if (q.size() == 0) begin
         exp_d = 8'h00; exp_e = 1'b1;
      end else begin
         exp_d = q.pop_front(); exp_e = 1'b0;
      end
      if (!en_rx) m_ovf = 1'b0;
      check_eq({tag, "_data"}, 32'(prdata), 32'(exp_d));
      check_eq({tag, "_err"}, 32'(pslverr), 32'(exp_e));
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_write_chk(input string tag);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
      tick();
      penable = 1'b1;
      @(negedge clk);
      check_eq({tag, "_err"}, 32'(pslverr), 32'd1);
      check_eq({tag, "_data"}, 32'(prdata), 32'd0);
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check_eq({tag, "_lvl"}, 32'(level), 32'(q.size()));
      check_eq({tag, "_mst"}, 32'(mem_state), 32'(q.size() != 0));
      check_eq({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
   endtask

   initial begin
      logic [7:0] w;
      int         budget;

      // reset state
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_lvl", 32'(level), 32'd0);
      check_eq("rst_mst", 32'(mem_state), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      check_eq("rst_prdata", 32'(prdata), 32'd0);
      check_eq("rst_pslverr", 32'(pslverr), 32'd0);
      check_eq("rst_pready", 32'(pready), 32'd1);
      tick();
      reset_n = 1'b1;
      en_rx   = 1'b1;
      tick();

      // single word, slow strobes, latency boundary
      send_word(8'hA5, 24);
      @(negedge clk);
      check_eq("t1_store_lvl", 32'(level), 32'd0);
      check_eq("t1_store_mst", 32'(mem_state), 32'd0);
      @(negedge clk);
      check_eq("t1_lvl", 32'(level), 32'd1);
      check_eq("t1_mst", 32'(mem_state), 32'd1);
      tick();
      apb_read_chk("t1_rd");
      check_status("t1_after");
      $display("t1 single word 0xA5 done, level=%0d", level);

      // partial word discarded when en_rx drops
      send_bit(1'b1); tick(); send_bit(1'b0); tick(); send_bit(1'b1);
      en_rx = 1'b0; tick();
      en_rx = 1'b1; tick();
      send_word(8'h3C, -1);
      repeat (2) tick();
      check_status("t2");
      apb_read_chk("t2_rd");
      $display("t2 abort then 0x3C done");

      // fill to full, then overflow
      for (int i = 0; i < DEPTH; i++) send_word(8'(i), -1);
      send_word(8'hFF, -1);
      repeat (3) tick();
      check_status("t3_full");
      check_eq("t3_ovf_set", 32'(overflow), 32'd1);
      apb_read_chk("t3_rd_en");
      check_status("t3_ovf_keep");
      en_rx = 1'b0;
      for (int i = 1; i < DEPTH; i++) apb_read_chk("t3_rd");
      check_status("t3_drained");
      $display("t3 fill/overflow/drain done, overflow=%0d", overflow);

      // full FIFO, read coinciding with the store cycle
      en_rx = 1'b1; tick();
      for (int i = 0; i < DEPTH; i++) send_word(8'($urandom), 0);
      repeat (3) tick();
      check_status("t4_full");
      w = 8'h77;
      for (int i = 0; i < 7; i++) send_bit(w[i]);
      data_in = w[7]; bit_valid = 1'b1;
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0;
      tick();
      bit_valid = 1'b0; penable = 1'b1;
      @(negedge clk);
      check_eq("t4_rd_data", 32'(prdata), 32'(q[0]));
      check_eq("t4_rd_err", 32'(pslverr), 32'd0);
      void'(q.pop_front());
      q.push_back(8'h77);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      check_status("t4_after");
      check_eq("t4_lvl64", 32'(level), 32'd64);
      for (int i = 0; i < DEPTH; i++) apb_read_chk("t4_rd");
      $display("t4 simultaneous push/pop on full done");

      // empty read and illegal write
      apb_read_chk("t5_empty");
      apb_write_chk("t5_wr_empty");
      check_status("t5_wr_empty_st");
      send_word(8'hC3, 0);
      repeat (2) tick();
      apb_write_chk("t5_wr");
      check_status("t5_wr_st");
      apb_read_chk("t5_rd");
      $display("t5 error responses done");

      // long concurrent run, pointers wrap several times
      budget = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               send_word(8'($urandom), -1);
               repeat ($urandom_range(0, 3)) tick();
            end
            sent_done = 1'b1;
         end
         begin
            while (!(sent_done && pending == 0 && q.size() == 0)) begin
               repeat ($urandom_range(0, 4)) tick();
               apb_read_chk("t6_rd");
               budget++;
               if (budget > 20000) begin
                  check_eq("t6_budget", 32'd1, 32'd0);
                  break;
               end
            end
         end
      join
      check_status("t6_end");
      $display("t6 concurrent run done after %0d reads", budget);

      // reset in the middle of a word
      send_word(8'h11, 0);
      send_word(8'h22, 0);
      repeat (2) tick();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      #5;
      reset_n = 1'b0;
      #1;
      check_eq("t7_rst_lvl", 32'(level), 32'd0);
      check_eq("t7_rst_mst", 32'(mem_state), 32'd0);
      check_eq("t7_rst_ovf", 32'(overflow), 32'd0);
      check_eq("t7_rst_prdata", 32'(prdata), 32'd0);
      check_eq("t7_rst_pslverr", 32'(pslverr), 32'd0);
      q.delete();
      m_ovf = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      send_word(8'h5A, -1);
      repeat (2) tick();
      check_status("t7_post");
      apb_read_chk("t7_rd");
      $display("t7 mid-word reset done");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
